// File: rtl/rom_load_sequencer_if.sv
// HPS ioctl download port plus core ROM write port and status, bundled for rom_load_sequencer.
// master is the sequencer side; slave is the HPS/core side.
interface rom_load_sequencer_if #(
    parameter int ADDR_W = 16
);
    logic              ioctl_download;
    logic              ioctl_wr;
    logic [ADDR_W-1:0] ioctl_addr;
    logic [7:0]        ioctl_dout;
    logic              ioctl_wait;
    logic              user_reset;
    logic              mem_busy;
    logic [3:0]        mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_data;
    logic              core_reset;
    logic              size_err;
    logic              overrun;

    modport master (
        input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, user_reset, mem_busy,
        output ioctl_wait, mem_we, mem_addr, mem_data, core_reset, size_err, overrun
    );

    modport slave (
        output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, user_reset, mem_busy,
        input  ioctl_wait, mem_we, mem_addr, mem_data, core_reset, size_err, overrun
    );
endinterface

// File: rtl/rom_load_sequencer.sv
// Routes HPS download bytes into four ROM regions through a 1-entry buffer (write strobe 1 cycle after
// ioctl_wr, held off by mem_busy with ioctl_wait raised while full) and sequences the core reset.
module rom_load_sequencer #(
    parameter int                ADDR_W      = 16,
    parameter logic [ADDR_W-1:0] R1_BASE     = 16'h6000,
    parameter logic [ADDR_W-1:0] R2_BASE     = 16'hA000,
    parameter logic [ADDR_W-1:0] R3_BASE     = 16'hC000,
    parameter logic [16:0]       TOTAL_SIZE  = 17'd49152,
    parameter int                HOLD_CYCLES = 1024
) (
    input  logic                 clk_sys,
    input  logic                 reset_n,
    rom_load_sequencer_if.master io
);
    localparam int              HC_W      = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HC_W-1:0] HOLD_LOAD = HC_W'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_HOLD, S_RUN, S_ERR} state_t;

    state_t            r_state;
    logic              r_full;
    logic              r_in_range;
    logic [1:0]        r_region;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_data;
    logic [16:0]       r_count;
    logic [HC_W-1:0]   r_hold;
    logic              r_dl_q;
    logic              r_core_reset;
    logic              r_size_err;
    logic              r_overrun;

    logic              w_dl_rise;
    logic              w_capture;
    logic              w_issue;
    logic              w_overrun;
    logic              w_load_start;
    logic              w_load_done;
    logic              w_in_range;
    logic [1:0]        w_region;
    logic [ADDR_W-1:0] w_base;
    logic [3:0]        w_we;

    assign w_dl_rise  = io.ioctl_download & ~r_dl_q;
    assign w_capture  = (r_state == S_LOAD) & io.ioctl_wr & ~r_full;
    assign w_overrun  = (r_state == S_LOAD) & io.ioctl_wr & r_full;
    assign w_issue    = (r_state == S_LOAD) & r_full & ~io.mem_busy;
    assign w_in_range = 17'(io.ioctl_addr) < TOTAL_SIZE;

    assign w_load_start = ((r_state == S_IDLE || r_state == S_HOLD) && io.ioctl_download) ||
                          ((r_state == S_RUN  || r_state == S_ERR)  && w_dl_rise);

    // A byte draining this cycle counts as empty, so settle starts right after the last strobe.
    assign w_load_done = (r_state == S_LOAD) && !io.ioctl_download && !w_capture &&
                         (!r_full || w_issue);

    always_comb begin
        w_region = 2'd3;
        w_base   = R3_BASE;
        if (io.ioctl_addr < R1_BASE) begin
            w_region = 2'd0;
            w_base   = '0;
        end else if (io.ioctl_addr < R2_BASE) begin
            w_region = 2'd1;
            w_base   = R1_BASE;
        end else if (io.ioctl_addr < R3_BASE) begin
            w_region = 2'd2;
            w_base   = R2_BASE;
        end
    end

    always_comb begin
        w_we = 4'b0000;
        if (w_issue && r_in_range) begin
            w_we[r_region] = 1'b1;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_full       <= 1'b0;
            r_in_range   <= 1'b0;
            r_region     <= 2'd0;
            r_addr       <= '0;
            r_data       <= '0;
            r_count      <= '0;
            r_hold       <= '0;
            r_dl_q       <= 1'b0;
            r_core_reset <= 1'b1;
            r_size_err   <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_dl_q <= io.ioctl_download;

            if (w_capture) begin
                r_full     <= 1'b1;
                r_addr     <= io.ioctl_addr - w_base;
                r_data     <= io.ioctl_dout;
                r_region   <= w_region;
                r_in_range <= w_in_range;
                if (r_count != '1) begin
                    r_count <= r_count + 17'd1;
                end
            end else if (w_issue) begin
                r_full <= 1'b0;
            end

            if (w_overrun) begin
                r_overrun <= 1'b1;
            end

            if (w_load_start) begin
                r_state      <= S_LOAD;
                r_count      <= '0;
                r_size_err   <= 1'b0;
                r_overrun    <= 1'b0;
                r_core_reset <= 1'b1;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_state <= S_HOLD;
                        r_hold  <= HOLD_LOAD;
                    end
                    S_LOAD: begin
                        if (w_load_done) begin
                            if (r_count == TOTAL_SIZE) begin
                                r_state <= S_HOLD;
                                r_hold  <= HOLD_LOAD;
                            end else begin
                                r_state    <= S_ERR;
                                r_size_err <= 1'b1;
                            end
                        end
                    end
                    S_HOLD: begin
                        if (io.user_reset) begin
                            r_hold <= HOLD_LOAD;
                        end else if (r_hold == '0) begin
                            r_state      <= S_RUN;
                            r_core_reset <= 1'b0;
                        end else begin
                            r_hold <= r_hold - HC_W'(1);
                        end
                    end
                    S_RUN: begin
                        if (io.user_reset) begin
                            r_state      <= S_HOLD;
                            r_hold       <= HOLD_LOAD;
                            r_core_reset <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign io.ioctl_wait = r_full;
    assign io.mem_we     = w_we;
    assign io.mem_addr   = r_addr;
    assign io.mem_data   = r_data;
    assign io.core_reset = r_core_reset;
    assign io.size_err   = r_size_err;
    assign io.overrun    = r_overrun;
endmodule

// File: tb/tb_rom_load_sequencer.sv
// Randomized bench for rom_load_sequencer on a scaled-down memory map (bases /256, 256-byte image)
// with a transaction-level write scoreboard and byte-count/flag model.
module tb_rom_load_sequencer;
    localparam int          AW  = 16;
    localparam logic [15:0] B1  = 16'h0060;
    localparam logic [15:0] B2  = 16'h00A0;
    localparam logic [15:0] B3  = 16'h00C0;
    localparam int          TOT = 256;
    localparam int          HC  = 1024;

    logic clk_sys = 1'b0;
    logic reset_n;
    always #5 clk_sys = ~clk_sys;

    rom_load_sequencer_if #(.ADDR_W(AW)) bus ();

    rom_load_sequencer #(
        .ADDR_W(AW), .R1_BASE(B1), .R2_BASE(B2), .R3_BASE(B3),
        .TOTAL_SIZE(17'(TOT)), .HOLD_CYCLES(HC)
    ) dut (
        .clk_sys(clk_sys),
        .reset_n(reset_n),
        .io     (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---- reference model ----
    typedef struct packed {
        logic [3:0]  we;
        logic [15:0] a;
        logic [7:0]  d;
    } wr_t;

    wr_t exp_q[$];
    int  m_count;
    bit  m_ovr;

    function automatic logic [3:0] ref_we(input int addr);
        if (addr >= TOT)       return 4'b0000;
        if (addr < int'(B1))   return 4'b0001;
        if (addr < int'(B2))   return 4'b0010;
        if (addr < int'(B3))   return 4'b0100;
        return 4'b1000;
    endfunction

    function automatic logic [15:0] ref_local(input int addr);
        if (addr < int'(B1)) return 16'(addr);
        if (addr < int'(B2)) return 16'(addr - int'(B1));
        if (addr < int'(B3)) return 16'(addr - int'(B2));
        return 16'(addr - int'(B3));
    endfunction

    always @(negedge clk_sys) begin
        wr_t e;
        if (bus.mem_we !== 4'b0000) begin
            if (exp_q.size() == 0) begin
                check_val("spurious_we", 32'(bus.mem_we), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_val("sb_we",   32'(bus.mem_we),   32'(e.we));
                check_val("sb_addr", 32'(bus.mem_addr), 32'(e.a));
                check_val("sb_data", 32'(bus.mem_data), 32'(e.d));
            end
        end
    end

    // ---- stimulus helpers ----
    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic check_reset_outputs();
        check_val("rst_core_reset", 32'(bus.core_reset), 32'd1);
        check_val("rst_mem_we",     32'(bus.mem_we),     32'd0);
        check_val("rst_mem_addr",   32'(bus.mem_addr),   32'd0);
        check_val("rst_mem_data",   32'(bus.mem_data),   32'd0);
        check_val("rst_wait",       32'(bus.ioctl_wait), 32'd0);
        check_val("rst_size_err",   32'(bus.size_err),   32'd0);
        check_val("rst_overrun",    32'(bus.overrun),    32'd0);
    endtask

    task automatic send_byte(input int addr, input logic [7:0] data, input int busy, input bit last);
        logic [3:0] ew;
        wr_t        e;
        ew = ref_we(addr);
        bus.ioctl_wr   = 1'b1;
        bus.ioctl_addr = 16'(addr);
        bus.ioctl_dout = data;
        bus.mem_busy   = (busy > 0);
        tick();
        bus.ioctl_wr = 1'b0;
        m_count++;
        if (ew != 4'b0000) begin
            e.we = ew; e.a = ref_local(addr); e.d = data;
            exp_q.push_back(e);
        end
        if (last) bus.ioctl_download = 1'b0;
        for (int k = 0; k < busy; k++) begin
            @(negedge clk_sys);
            check_val("wait_busy", 32'(bus.ioctl_wait), 32'd1);
            check_val("we_busy",   32'(bus.mem_we),     32'd0);
            tick();
        end
        bus.mem_busy = 1'b0;
        @(negedge clk_sys);
        check_val("wait_drain", 32'(bus.ioctl_wait), 32'd1);
        check_val("we_latency", 32'(bus.mem_we), 32'(ew));
        if (addr == int'(B1) - 1) begin
            check_val("bnd_r0_top_we",   32'(bus.mem_we),   32'h1);
            check_val("bnd_r0_top_addr", 32'(bus.mem_addr), 32'h5F);
        end
        if (addr == int'(B1)) begin
            check_val("bnd_r1_base_we",   32'(bus.mem_we),   32'h2);
            check_val("bnd_r1_base_addr", 32'(bus.mem_addr), 32'h0);
        end
        if (addr == int'(B2) + 5) begin
            check_val("bp_we",   32'(bus.mem_we),   32'h4);
            check_val("bp_addr", 32'(bus.mem_addr), 32'h5);
        end
        if (addr == int'(B3)) begin
            check_val("bnd_r3_base_we",   32'(bus.mem_we),   32'h8);
            check_val("bnd_r3_base_addr", 32'(bus.mem_addr), 32'h0);
        end
        if (!last) begin
            tick();
            check_val("wait_clear", 32'(bus.ioctl_wait), 32'd0);
            repeat ($urandom_range(0, 2)) tick();
        end
    endtask

    // Byte i goes to first+i, or past the image end for the last `oor` bytes.
    task automatic load_image(input int first, input int n, input int oor, input int busy_idx, input bit do_last);
        int addr;
        int busy;
        for (int i = 0; i < n; i++) begin
            addr = (i >= n - oor) ? TOT + i : first + i;
            if (addr == busy_idx)               busy = 10;
            else if ($urandom_range(0, 3) == 0) busy = $urandom_range(1, 4);
            else                                busy = 0;
            send_byte(addr, 8'($urandom), busy, do_last && (i == n - 1));
        end
    endtask

    // Second strobe lands while the first byte is held by mem_busy.
    task automatic send_overrun(input int addr, input int addr2);
        wr_t e;
        bus.mem_busy   = 1'b1;
        bus.ioctl_wr   = 1'b1;
        bus.ioctl_addr = 16'(addr);
        bus.ioctl_dout = 8'($urandom);
        tick();
        m_count++;
        e.we = ref_we(addr); e.a = ref_local(addr); e.d = bus.ioctl_dout;
        exp_q.push_back(e);
        bus.ioctl_addr = 16'(addr2);
        bus.ioctl_dout = 8'($urandom);
        @(negedge clk_sys);
        check_val("ovr_wait", 32'(bus.ioctl_wait), 32'd1);
        tick();
        bus.ioctl_wr = 1'b0;
        m_ovr = 1'b1;
        check_val("ovr_flag", 32'(bus.overrun), 32'(m_ovr));
        tick();
        bus.mem_busy = 1'b0;
        @(negedge clk_sys);
        check_val("ovr_drain_we", 32'(bus.mem_we), 32'(ref_we(addr)));
        tick();
    endtask

    task automatic start_download();
        bus.ioctl_download = 1'b1;
        tick();
        m_count = 0;
        m_ovr   = 1'b0;
        check_val("entry_size_err", 32'(bus.size_err),   32'd0);
        check_val("entry_overrun",  32'(bus.overrun),    32'd0);
        check_val("load_core_rst",  32'(bus.core_reset), 32'd1);
    endtask

    task automatic expect_release(input int edges, input string tag);
        int n;
        n = 0;
        while (bus.core_reset !== 1'b0 && n <= edges + 50) begin
            tick();
            n++;
        end
        check_val(tag, 32'(n), 32'(edges));
    endtask

    task automatic expect_stuck(input int cycles, input string tag);
        repeat (cycles) tick();
        check_val(tag, 32'(bus.core_reset), 32'd1);
    endtask

    task automatic check_flags(input string tag);
        check_val({tag, "_size_err"}, 32'(bus.size_err), 32'(m_count != TOT));
        check_val({tag, "_overrun"},  32'(bus.overrun),  32'(m_ovr));
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.ioctl_download = 1'b0;
        bus.ioctl_wr       = 1'b0;
        bus.ioctl_addr     = '0;
        bus.ioctl_dout     = '0;
        bus.user_reset     = 1'b0;
        bus.mem_busy       = 1'b0;
        m_count            = 0;
        m_ovr              = 1'b0;
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #20;
        check_reset_outputs();
        tick();
        reset_n = 1'b1;
        // one IDLE cycle, then the settle period
        expect_release(HC + 1, "rel_after_reset");

        // full image, random data and random short stalls
        start_download();
        load_image(0, TOT, 0, -1, 1'b1);
        expect_release(HC + 1, "rel_full");
        check_flags("full");

        // 10-cycle stall on B2+5, plus two out-of-image addresses that count but never strobe
        start_download();
        load_image(0, TOT, 2, int'(B2) + 5, 1'b1);
        expect_release(HC + 1, "rel_bp");
        check_flags("bp");

        // TOT strobes, one dropped by overrun -> short count
        start_download();
        send_overrun(0, 1);
        load_image(2, TOT - 2, 0, -1, 1'b1);
        expect_stuck(HC + 20, "ovr_err_core_rst");
        check_flags("ovr");
        start_download();
        load_image(0, TOT, 0, -1, 1'b1);
        expect_release(HC + 1, "rel_after_ovr");
        check_flags("ovr_reload");

        // short image: ERR ignores user_reset
        start_download();
        load_image(0, 100, 0, -1, 1'b1);
        expect_stuck(HC + 20, "short_err_core_rst");
        check_flags("short");
        bus.user_reset = 1'b1;
        repeat (5) tick();
        bus.user_reset = 1'b0;
        expect_stuck(HC + 20, "err_user_reset");
        start_download();
        load_image(0, TOT, 0, -1, 1'b1);
        expect_release(HC + 1, "rel_after_short");

        // 5-cycle user reset in RUN
        bus.user_reset = 1'b1;
        tick();
        check_val("ures_immediate", 32'(bus.core_reset), 32'd1);
        repeat (4) tick();
        bus.user_reset = 1'b0;
        expect_release(HC, "rel_user_reset");

        // download rising together with user_reset: download wins
        bus.ioctl_download = 1'b1;
        bus.user_reset     = 1'b1;
        tick();
        bus.user_reset = 1'b0;
        m_count = 0;
        m_ovr   = 1'b0;
        load_image(0, TOT, 0, -1, 1'b1);
        expect_release(HC + 1, "rel_dl_vs_ures");
        check_flags("dl_vs_ures");

        // async reset with a byte stuck in the buffer and overrun set
        start_download();
        load_image(0, 50, 0, -1, 1'b0);
        bus.mem_busy   = 1'b1;
        bus.ioctl_wr   = 1'b1;
        bus.ioctl_addr = 16'd50;
        bus.ioctl_dout = 8'($urandom);
        tick();
        bus.ioctl_addr = 16'd51;
        tick();
        bus.ioctl_wr = 1'b0;
        check_val("pre_rst_overrun", 32'(bus.overrun),    32'd1);
        check_val("pre_rst_wait",    32'(bus.ioctl_wait), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check_reset_outputs();
        exp_q.delete();
        m_count = 0;
        m_ovr   = 1'b0;
        bus.mem_busy = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        load_image(52, TOT - 52, 0, -1, 1'b1);
        expect_stuck(HC + 20, "rst_mid_err_core_rst");
        check_flags("rst_mid");

        check_val("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/rom_load_sequencer.md
Name: rom_load_sequencer

Overview:
- Sits between hps_io's ioctl download port and the arcade core's ROM/PROM write port.
- Decodes the flat download address into per-region write strobes and region-local addresses.
- Buffers each byte until the core's memory port accepts it, back-pressuring HPS via ioctl_wait.
- Sequences the core reset: held through download plus a settle period, released only after a correctly sized image.

Parameters:
ADDR_W, 16, width of download address and region-local address.
R1_BASE, 16'h6000, first address of region 1; region 0 is 0..R1_BASE-1.
R2_BASE, 16'hA000, first address of region 2.
R3_BASE, 16'hC000, first address of region 3; region 3 runs to TOTAL_SIZE-1.
TOTAL_SIZE, 17'd49152, exact byte count of a valid image.
HOLD_CYCLES, 1024, core-reset settle cycles after download or user reset (>=1).

Ports:
clk_sys  in  1  system clock.
reset_n  in  1  asynchronous active-low reset.
ioctl_download  in  1  download in progress.
ioctl_wr  in  1  one-cycle byte strobe.
ioctl_addr  in  ADDR_W  byte address.
ioctl_dout  in  8  byte data.
ioctl_wait  out  1  back-pressure to hps_io.
user_reset  in  1  level reset request (OSD reset OR button).
mem_busy  in  1  core memory port cannot accept a write this cycle.
mem_we  out  4  one-hot region write strobe.
mem_addr  out  ADDR_W  region-local address (ioctl_addr - region base).
mem_data  out  8  write data.
core_reset  out  1  active-high reset to the core.
size_err  out  1  sticky: last download byte count != TOTAL_SIZE.
overrun  out  1  sticky: ioctl_wr arrived while the buffer was full.

Behaviour:
- Reset (reset_n=0) forces:
  - state=IDLE, core_reset=1, mem_we=0, mem_addr=0, mem_data=0, ioctl_wait=0, size_err=0, overrun=0.
  - Byte counter=0, buffer empty.
- States:
  - IDLE: core_reset=1. ioctl_download=1 -> LOAD, else -> HOLD.
  - LOAD:
    - Entry clears byte counter, size_err and overrun.
    - Leaves only on ioctl_download falling AND buffer empty.
    - If download falls with a pending byte, the byte drains first, then the state advances.
    - Count == TOTAL_SIZE -> HOLD; otherwise set size_err -> ERR.
  - HOLD: core_reset=1, counter loads HOLD_CYCLES-1 on entry; at 0 -> RUN.
  - RUN: core_reset=0.
    - ioctl_download rising -> LOAD.
    - user_reset=1 -> HOLD.
  - ERR: core_reset=1. Only ioctl_download rising -> LOAD; user_reset ignored.
- Priority when events coincide: ioctl_download > user_reset.
  - In HOLD, ioctl_download -> LOAD.
  - In HOLD, user_reset=1 reloads the counter every cycle, so release occurs HOLD_CYCLES cycles after user_reset falls.
- Buffer (1 entry):
  - ioctl_wr in LOAD with buffer empty captures addr/data, marks full and increments the byte counter (17 bits, saturating at all-ones).
  - Registered region decode:
    - addr < R1_BASE -> 0.
    - addr < R2_BASE -> 1.
    - addr < R3_BASE -> 2.
    - else 3.
  - Addresses >= TOTAL_SIZE are counted but produce no strobe.
  - mem_addr = addr - base[region], truncated to ADDR_W.
- Issue:
  - While full and mem_busy=0, mem_we[region] pulses for exactly one cycle and the buffer empties the same cycle.
  - Minimum latency is ioctl_wr at cycle N -> mem_we at cycle N+1.
  - mem_addr and mem_data stay stable while full.
- ioctl_wait=1 whenever the buffer is full, combinationally.
- ioctl_wr while full (HPS ignored wait): the byte is dropped, not counted, and overrun is set.
- ioctl_wr outside LOAD is ignored.
- mem_we never asserts outside LOAD.
- Async reset mid-download: the buffer is discarded. After reset_n rises with ioctl_download still 1, the block goes IDLE -> LOAD and counts only the remaining bytes, which yields size_err.

Test Plan:
- Full load: 49152 bytes at addr 0..0xBFFF, one per 4 cycles, mem_busy=0.
  - Each byte gives a mem_we pulse at +1 cycle.
  - 0x5FFF -> we=0001, mem_addr 0x5FFF.
  - 0x6000 -> we=0010, mem_addr 0x0000.
  - 0xC000 excluded.
  - core_reset falls exactly 1024 cycles after the last drain; size_err=0.
- Back-pressure: mem_busy=1 for 10 cycles after the write to addr 0xA005.
  - ioctl_wait=1 for those cycles.
  - Single we=0100 pulse with mem_addr 0x0005 on the first non-busy cycle.
- Overrun: second ioctl_wr while ioctl_wait=1.
  - overrun=1, count excludes the dropped byte, size_err=1.
  - Then a new valid download clears both flags.
- Short image: 1000 bytes then download falls.
  - State ERR, core_reset stays 1; user_reset has no effect.
  - Full reload releases core_reset.
- User reset in RUN: 5-cycle user_reset pulse.
  - core_reset=1 immediately, falls 1024 cycles after user_reset deasserts.
  - Simultaneous ioctl_download rising takes LOAD.
- reset_n=0 mid-download with the buffer full.
  - All outputs reach reset values asynchronously; no mem_we is issued.
  - Continued download after release ends in ERR.
